xor_parity_rx: RTL and testbench

- Serial frame receiver that recovers a data word and checks it against the transmitted XOR parity bit.
- Sits at the receiving end of a single-bit serial link. The far end uses a parity generator built from the team's XOR cells.
- Accumulates a running XOR of received data bits, compares it with the parity bit, and reports parity and framing errors with each word.

---
 rtl/xor_parity_rx.sv | 141 ++++++++++++++
 tb/tb_xor_parity_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/xor_parity_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, XOR parity bit, stop bit.
// Reports the recovered word with parity and framing status as a one-cycle data_valid pulse.
module xor_parity_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
    localparam logic          ODD       = (ODD_PARITY != 0);

    // state  | meaning
    // IDLE   | line idle, waiting for a falling edge
    // START  | timing to mid start bit to confirm it is not a glitch
    // DATA   | sampling DATA_W data bits at bit centres
    // PARITY | sampling the transmitted parity bit
    // STOP   | sampling the stop bit and publishing the frame
    // BREAK  | stop bit was low; wait for the line to return high
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              par_acc;
    logic              par_bit;
    logic              tick;

    // Down-counter reaching zero marks the sampling point of the current bit.
    assign tick = (cnt == '0);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_in) begin
                        state   <= START;
                        cnt     <= HALF_LOAD;
                        bit_idx <= '0;
                        par_acc <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rx_in) begin
                            state <= DATA;
                            cnt   <= BIT_LOAD;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg[bit_idx] <= rx_in;
                        par_acc        <= par_acc ^ rx_in;
                        cnt            <= BIT_LOAD;
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            state   <= PARITY;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PARITY: begin
                    if (tick) begin
                        par_bit <= rx_in;
                        cnt     <= BIT_LOAD;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        // Errors never suppress the pulse; both flags travel with the word.
                        data_out   <= shreg;
                        parity_err <= par_acc ^ par_bit ^ ODD;
                        frame_err  <= ~rx_in;
                        data_valid <= 1'b1;
                        cnt        <= '0;
                        state      <= rx_in ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_in) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_parity_rx.sv
// Bench for xor_parity_rx: an even- and an odd-parity instance share one serial line,
// expected frames are queued as they are sent and compared when data_valid pulses.
module tb_xor_parity_rx;

    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int LAT = 2 + (DW + 2) * CPB;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          rx_in = 1'b1;
    logic [DW-1:0] do_e, do_o;
    logic          dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, bz_e, bz_o;

    always #5 clk = ~clk;

    xor_parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .ODD_PARITY(0)) dut_e (
        .clk(clk), .rst(rst), .rx_in(rx_in), .data_out(do_e), .data_valid(dv_e),
        .parity_err(pe_e), .frame_err(fe_e), .busy(bz_e)
    );

    xor_parity_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .ODD_PARITY(1)) dut_o (
        .clk(clk), .rst(rst), .rx_in(rx_in), .data_out(do_o), .data_valid(dv_o),
        .parity_err(pe_o), .frame_err(fe_o), .busy(bz_o)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          pe;
        logic          fe;
    } exp_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          pb;
        logic          sb;
        logic          pe;
        logic          fe;
        int            extra_low;
    } vec_t;

    exp_t q_e[$];
    exp_t q_o[$];
    exp_t x_e, x_o;
    vec_t tbl[7];

    int errors     = 0;
    int checks     = 0;
    int cyc        = 0;
    int last_pulse = -1000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: pop and compare whenever either instance pulses data_valid.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (dv_e || dv_o) begin
            check("valid_align", dv_o, dv_e);
            if (dv_e) begin
                last_pulse = cyc;
                checks++;
                if (q_e.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid_even: got data 0x%0h with no frame pending", do_e);
                end else begin
                    x_e = q_e.pop_front();
                    check("even_data", do_e, x_e.d);
                    check("even_parity_err", pe_e, x_e.pe);
                    check("even_frame_err", fe_e, x_e.fe);
                end
            end
            if (dv_o) begin
                checks++;
                if (q_o.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid_odd: got data 0x%0h with no frame pending", do_o);
                end else begin
                    x_o = q_o.pop_front();
                    check("odd_data", do_o, x_o.d);
                    check("odd_parity_err", pe_o, x_o.pe);
                    check("odd_frame_err", fe_o, x_o.fe);
                end
            end
        end
    end

    task automatic drive_bit(input logic v, input int n);
        @(negedge clk);
        rx_in = v;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pb, input logic sb,
                              input int stop_len, input logic exp_pe, input logic exp_fe);
        int   e0;
        exp_t ee;
        exp_t eo;
        ee.d  = d;
        ee.pe = exp_pe;
        ee.fe = exp_fe;
        eo.d  = d;
        eo.pe = ~exp_pe;
        eo.fe = exp_fe;
        q_e.push_back(ee);
        q_o.push_back(eo);
        @(negedge clk);
        rx_in = 1'b0;
        e0    = cyc + 1;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < DW; i++) drive_bit(d[i], CPB);
        drive_bit(pb, CPB);
        drive_bit(sb, stop_len);
        @(posedge clk);
        #2;
        check("valid_latency", last_pulse - e0, LAT);
        if (sb) check("busy_after_frame", bz_e, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_e"}, do_e, 0);
        check({tag, "_valid_e"}, dv_e, 0);
        check({tag, "_perr_e"}, pe_e, 0);
        check({tag, "_ferr_e"}, fe_e, 0);
        check({tag, "_busy_e"}, bz_e, 0);
        check({tag, "_data_o"}, do_o, 0);
        check({tag, "_perr_o"}, pe_o, 0);
        check({tag, "_busy_o"}, bz_o, 0);
    endtask

    initial begin
        #100000;
        errors++;
        checks++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int nb;
        int p1;
        int p2;

        tbl[0] = '{d: 8'hA5, pb: 1'b0, sb: 1'b1, pe: 1'b0, fe: 1'b0, extra_low: 0};
        tbl[1] = '{d: 8'hA5, pb: 1'b1, sb: 1'b1, pe: 1'b1, fe: 1'b0, extra_low: 0};
        tbl[2] = '{d: 8'h3C, pb: 1'b0, sb: 1'b0, pe: 1'b0, fe: 1'b1, extra_low: 20};
        tbl[3] = '{d: 8'h00, pb: 1'b1, sb: 1'b1, pe: 1'b1, fe: 1'b0, extra_low: 0};
        tbl[4] = '{d: 8'h80, pb: 1'b0, sb: 1'b1, pe: 1'b1, fe: 1'b0, extra_low: 0};
        tbl[5] = '{d: 8'h5A, pb: 1'b1, sb: 1'b1, pe: 1'b1, fe: 1'b0, extra_low: 0};
        tbl[6] = '{d: 8'hC3, pb: 1'b0, sb: 1'b1, pe: 1'b0, fe: 1'b0, extra_low: 0};

        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            send_frame(tbl[k].d, tbl[k].pb, tbl[k].sb, CPB, tbl[k].pe, tbl[k].fe);
            if (tbl[k].extra_low > 0) begin
                // Line stays low: receiver must sit in BREAK, never restarting.
                for (int j = 0; j < tbl[k].extra_low; j++) begin
                    @(negedge clk);
                    check("break_busy", bz_e, 1'b1);
                end
                @(negedge clk);
                rx_in = 1'b1;
                @(negedge clk);
                check("break_exit_busy", bz_e, 1'b0);
                repeat (3) @(negedge clk);
            end
        end

        // One-cycle low glitch from idle.
        @(negedge clk);
        rx_in = 1'b0;
        nb    = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) rx_in = 1'b1;
            if (bz_e) nb++;
        end
        check("glitch_busy_cycles", nb, 2);
        check("glitch_data_hold", do_e, 8'hC3);
        check("glitch_perr_hold_e", pe_e, 1'b0);
        check("glitch_perr_hold_o", pe_o, 1'b1);
        check("glitch_ferr_hold", fe_e, 1'b0);

        // Back-to-back: second start lands on the first edge after the stop sample.
        send_frame(8'h01, 1'b1, 1'b1, CPB - 1, 1'b0, 1'b0);
        p1 = last_pulse;
        send_frame(8'hFF, 1'b0, 1'b1, CPB, 1'b0, 1'b0);
        p2 = last_pulse;
        check("b2b_spacing", p2 - p1, LAT + 1);

        send_frame(8'h80, 1'b0, 1'b1, CPB, 1'b1, 1'b0);

        // Reset during data bit 4 of 0x55.
        @(negedge clk);
        rx_in = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 4; i++) drive_bit(((8'h55 >> i) & 8'h01) != 0, CPB);
        @(negedge clk);
        rx_in = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midframe_reset");
        repeat (30) @(negedge clk);
        check("reset_no_valid_busy", bz_e, 1'b0);

        send_frame(8'h55, 1'b0, 1'b1, CPB, 1'b0, 1'b0);

        repeat (10) @(negedge clk);
        check("even_queue_drained", q_e.size(), 0);
        check("odd_queue_drained", q_o.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
